// File: rtl/opfetch_stage.sv
// Decode-stage operand fetch: register-file read, priority forwarding, load-use
// scoreboard and a registered valid/ready output. Scoreboard built only with OPFETCH_SCOREBOARD_EN.
module opfetch_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NFWD     = 3,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    output logic [5*NREAD-1:0]      rf_ra,
    input  logic [XLEN*NREAD-1:0]   rf_rd,
    input  logic [NFWD-1:0]         fwd_valid,
    input  logic [5*NFWD-1:0]       fwd_rd,
    input  logic [XLEN*NFWD-1:0]    fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [XLEN*NREAD-1:0]   out_rs,
    output logic [31:0]             stall_cnt
);

    localparam int unsigned RW = 5;

    logic [RW-1:0]          ra [NREAD];
    logic [XLEN*NREAD-1:0]  opnd_flat;
    logic                   hazard;
    logic                   accept;

    // Source register fields, independent of in_valid
    always_comb begin
        ra    = '{default: '0};
        rf_ra = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            case (i)
                0:       ra[i] = in_inst[19:15];
                1:       ra[i] = in_inst[24:20];
                default: ra[i] = in_inst[31:27];
            endcase
            rf_ra[i*RW +: RW] = ra[i];
        end
    end

    // Operand resolve: scan oldest to youngest so the lowest index wins; x0 is always zero
    always_comb begin
        opnd_flat = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            opnd_flat[i*XLEN +: XLEN] = rf_rd[i*XLEN +: XLEN];
            for (int j = int'(NFWD) - 1; j >= 0; j--) begin
                if (fwd_valid[j] && (fwd_rd[j*RW +: RW] == ra[i])) begin
                    opnd_flat[i*XLEN +: XLEN] = fwd_data[j*XLEN +: XLEN];
                end
            end
            if (ra[i] == '0) begin
                opnd_flat[i*XLEN +: XLEN] = '0;
            end
        end
    end

`ifdef OPFETCH_SCOREBOARD_EN
    localparam int unsigned CW = $clog2(LOAD_LAT + 1);
    localparam logic [6:0]  OP_LOAD = 7'b0000011;

    logic [CW-1:0]    sb_cnt [32];
    logic [NREAD-1:0] fwd_hit;
    logic             is_load;

    assign is_load = (in_inst[6:0] == OP_LOAD);

    // A pending load blocks a port unless some forwarding source already carries it
    always_comb begin
        hazard  = 1'b0;
        fwd_hit = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            for (int j = 0; j < int'(NFWD); j++) begin
                if (fwd_valid[j] && (fwd_rd[j*RW +: RW] == ra[i])) begin
                    fwd_hit[i] = 1'b1;
                end
            end
            if ((ra[i] != '0) && (sb_cnt[ra[i]] != '0) && !fwd_hit[i]) begin
                hazard = 1'b1;
            end
        end
    end

    // Entry 0 is never set, so x0 can never report busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                sb_cnt[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (accept && is_load && (in_inst[11:7] == RW'(k))) begin
                    sb_cnt[k] <= CW'(LOAD_LAT);
                end else if (sb_cnt[k] != '0) begin
                    sb_cnt[k] <= sb_cnt[k] - CW'(1);
                end
            end
            if (in_valid && hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign hazard    = 1'b0;
    assign stall_cnt = '0;
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Output stage; flush dominates since it also blocks accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_rs    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= in_inst;
            out_rs    <= opnd_flat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/opfetch_stage.md
# opfetch_stage

Parametrised decode-stage operand fetch: extracts source register indices from the instruction, reads the asynchronous register file, and resolves each operand through a priority-ordered multi-source forwarding network. It also detects load-use hazards with a per-register scoreboard and presents the instruction plus resolved operands to execute through a registered valid/ready stage. It sits between fetch/decode and execute in the core pipeline.

## Interface
Parameters:
- XLEN, 32, operand width
- NREAD, 2, read ports (1–3); port0=inst[19:15], port1=inst[24:20], port2=inst[31:27]
- NFWD, 3, forwarding sources; index 0 = youngest = highest priority
- LOAD_LAT, 2, cycles a load's rd stays unforwardable after leaving this stage (1–7)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_inst  in  32  instruction word
- rf_ra  out  5*NREAD  register-file read addresses, port i at [5i+4:5i]
- rf_rd  in  XLEN*NREAD  register-file read data (combinational)
- fwd_valid  in  NFWD  forwarding source j carries a result
- fwd_rd  in  5*NFWD  destination index of source j
- fwd_data  in  XLEN*NFWD  result of source j
- flush  in  1  kill instruction held in output register and refuse input
- out_valid  out  1  execute-side valid
- out_ready  in  1  execute accepts
- out_inst  out  32  registered instruction
- out_rs  out  XLEN*NREAD  registered resolved operands
- stall_cnt  out  32  saturating count of hazard-stall cycles

## Operation
- rf_ra driven combinationally from in_inst every cycle, regardless of in_valid.
- Operand resolve, per port i, address a: a==0 -> 0; else lowest j with fwd_valid[j] && fwd_rd[j]==a -> fwd_data[j]; else rf_rd[i]. Forwarding never targets x0.
- Load detection: in_inst[6:0]==7'b0000011.
- Scoreboard: 31 counters (x1–x31), width clog2(LOAD_LAT+1). On accept of a load with rd=in_inst[11:7]!=0, counter[rd] <= LOAD_LAT. Every other nonzero counter decrements by 1 per cycle. Same-cycle set and decrement on one entry: set wins.
- Hazard: any active port i with a!=0, counter[a]!=0, and no matching valid forwarding source.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. Accept = in_valid && in_ready.
- Output register: on accept, load out_inst/out_rs, out_valid<=1. Else if out_ready, out_valid<=0. flush forces out_valid<=0 (priority over accept, which cannot occur under flush).
- Flush does not clear the scoreboard; in-flight counters drain normally (conservative).
- stall_cnt increments each cycle in_valid && hazard, saturating at 32'hFFFF_FFFF.
- Unused ports (index >= NREAD) do not exist; hazard ignores them.

## Timing
- Reset (rst_n low, async): out_valid=0, out_inst=0, out_rs=0, all scoreboard counters=0, stall_cnt=0. in_ready and rf_ra follow their combinational equations immediately.
- Latency: accepted at edge N -> out_valid/out_rs visible after edge N, one cycle.
- Full throughput: back-to-back accepts when out_ready=1 and no hazard.
- Backpressure: out_valid && !out_ready holds all outputs stable and drops in_ready.
- Load then dependent instruction, no forwarding: dependent stalls exactly LOAD_LAT cycles after the load is accepted.
- Reset mid-stall clears counters; the next cycle after rst_n rises the held instruction is accepted.

## Configuration
- OPFETCH_SCOREBOARD_EN defined: scoreboard, hazard logic and stall_cnt as specified.
- Undefined: no counters; hazard tied 0; stall_cnt tied 0; LOAD_LAT ignored; in_ready = (!out_valid || out_ready) && !flush. Load-use resolution is then the responsibility of the execute stage.

## Test plan
- Reset then in_inst=add x3,x1,x2, rf_rd={20,10}, no forwarding, out_ready=1 -> one cycle later out_valid=1, out_rs={20,10}.
- x1 matched by fwd 0 (=0xAA) and fwd 2 (=0xCC), x2 by fwd 1 (=0xBB) -> out_rs={0xBB,0xAA}; rs1=x0 with fwd_rd=0 valid -> operand 0.
- lw x5 accepted, then add x6,x5,x5, no forwarding, LOAD_LAT=2 -> in_ready low 2 cycles, stall_cnt=2, then accepted; with fwd_valid[1] on x5 in stall cycle 1 -> accepted immediately.
- out_ready=0 for 3 cycles with out_valid=1 -> out_inst/out_rs unchanged, in_ready=0; out_ready=1 -> next instruction in following cycle.
- flush with out_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush; scoreboard entry from a prior load still blocks dependent for remaining cycles.
- rst_n low during load-use stall -> counters, stall_cnt, out_valid zero asynchronously; dependent accepted the cycle after release.
